// File: rtl/bus_dma_master.sv
// Single-channel bus copy engine: reads a word from the source range,
// writes it to the destination range, and repeats for the requested length.
module bus_dma_master #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [7:0]    length,
  output logic          busy,
  output logic          done,
  output logic          m_req,
  input  logic          m_grant,
  output logic          m_wr,
  output logic [AW-1:0] m_address,
  output logic [DW-1:0] m_dout,
  input  logic [DW-1:0] m_din
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RD,
    S_RDW,
    S_WR,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [7:0]    r_cnt;
  logic [DW-1:0] r_data;
  logic          r_busy;
  logic          r_done;
  logic          r_req;
  logic          r_wr;
  logic [AW-1:0] r_addr;

  logic [AW-1:0] w_src_nx;
  logic [AW-1:0] w_dst_nx;
  logic          w_last;

  // Pointers wrap naturally at the address width.
  assign w_src_nx = r_src + 1'b1;
  assign w_dst_nx = r_dst + 1'b1;
  assign w_last   = (r_cnt == 8'd1);

  assign busy      = r_busy;
  assign done      = r_done;
  assign m_req     = r_req;
  assign m_wr      = r_wr;
  assign m_address = r_addr;
  assign m_dout    = r_data;

  // Transfer FSM; bus outputs are registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_cnt   <= '0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_req   <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src <= src_addr;
            r_dst <= dst_addr;
            r_cnt <= length;
            if (length == 8'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_REQ;
              r_busy  <= 1'b1;
              r_req   <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (m_grant) begin
            r_state <= S_RD;
            r_wr    <= 1'b0;
            r_addr  <= r_src;
          end
        end
        S_RD: begin
          if (m_grant) begin
            r_state <= S_RDW;
          end
        end
        S_RDW: begin
          if (m_grant) begin
            r_state <= S_WR;
            r_data  <= m_din;
            r_wr    <= 1'b1;
            r_addr  <= r_dst;
          end
        end
        S_WR: begin
          if (m_grant) begin
            r_src <= w_src_nx;
            r_dst <= w_dst_nx;
            r_cnt <= r_cnt - 8'd1;
            r_wr  <= 1'b0;
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_req   <= 1'b0;
            end else begin
              r_state <= S_RD;
              r_addr  <= w_src_nx;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_req   <= 1'b0;
          r_wr    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_dma_master.sv
// Bench for bus_dma_master: bus slave memory, one-cycle arbiter,
// and a copy-level model of the expected writes and handshake timing.
module tb_bus_dma_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  src_addr = '0;
  logic [7:0]  dst_addr = '0;
  logic [7:0]  length = '0;
  logic        busy;
  logic        done;
  logic        m_req;
  logic        m_grant;
  logic        m_wr;
  logic [7:0]  m_address;
  logic [31:0] m_dout;
  logic [31:0] m_din;

  bus_dma_master #(.AW(8), .DW(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .m_req     (m_req),
    .m_grant   (m_grant),
    .m_wr      (m_wr),
    .m_address (m_address),
    .m_dout    (m_dout),
    .m_din     (m_din)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // arbiter grants one cycle after request; force_low models grant loss
  logic grant_q = 1'b0;
  logic force_low = 1'b0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) grant_q <= 1'b0;
    else grant_q <= m_req;
  end
  assign m_grant = grant_q & ~force_low;

  // slave memory: combinational read, write at the clock edge
  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  logic [31:0] tmp [256];
  int n_wr = 0;
  assign m_din = mem[m_address];
  always @(posedge clk) begin
    if (m_req && m_grant && m_wr) begin
      mem[m_address] = m_dout;
      n_wr = n_wr + 1;
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // model state
  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t  q[$];
  wr_t  w;
  bit   armed = 1'b0;
  bit   chk_en = 1'b0;
  int   s_cyc = 0;
  int   d_cyc = 0;
  logic be;
  logic de;

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      be = armed && (cyc >= s_cyc) && (cyc < d_cyc);
      de = armed && (cyc == d_cyc);
      chk("busy", {63'd0, busy}, {63'd0, be});
      chk("done", {63'd0, done}, {63'd0, de});
      chk("m_req", {63'd0, m_req}, {63'd0, be});
      if (!be) chk("m_wr_idle", {63'd0, m_wr}, 64'd0);
      if (m_req && m_grant && m_wr) begin
        if (q.size() == 0) begin
          chk("unexpected_write", 64'd1, 64'd0);
        end else begin
          w = q.pop_front();
          chk("wr_addr", {56'd0, m_address}, {56'd0, w.a});
          chk("wr_data", {32'd0, m_dout}, {32'd0, w.d});
          shadow[w.a] = w.d;
        end
      end
    end
  end

  task automatic set_mem(input logic [7:0] a, input logic [31:0] d);
    mem[a] = d;
    shadow[a] = d;
  endtask

  // launch a transfer and derive its expected writes and done cycle
  task automatic do_start(input logic [7:0] s, input logic [7:0] d,
                          input logic [7:0] l, input int stall);
    logic [7:0] as;
    logic [7:0] ad;
    @(negedge clk);
    tmp = shadow;
    for (int i = 0; i < int'(l); i++) begin
      as = s + 8'(i);
      ad = d + 8'(i);
      tmp[ad] = tmp[as];
      q.push_back({ad, tmp[as]});
    end
    s_cyc = cyc + 1;
    d_cyc = (l == 8'd0) ? s_cyc : s_cyc + 3 * int'(l) + 2 + stall;
    armed = 1'b1;
    start = 1'b1;
    src_addr = s;
    dst_addr = d;
    length = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  // watch a transfer; optional start poke and grant stall
  task automatic observe(input int maxc, input int poke_k,
                         input int stall_k, input logic [7:0] stall_a,
                         output int lat, output int nb, output int nd);
    lat = -1;
    nb = 0;
    nd = 0;
    for (int k = 0; k < maxc; k++) begin
      if (k == poke_k) begin
        start = 1'b1;
        src_addr = 8'h80;
        dst_addr = 8'h90;
        length = 8'd2;
      end
      if (k == poke_k + 1) start = 1'b0;
      if (k == stall_k) force_low = 1'b1;
      if (k == stall_k + 3) force_low = 1'b0;
      if (force_low) chk("stall_addr", {56'd0, m_address}, {56'd0, stall_a});
      if (busy) nb++;
      if (done) begin
        nd++;
        if (lat < 0) lat = cyc - s_cyc;
        chk("req_in_done", {63'd0, m_req}, 64'd0);
      end
      @(negedge clk);
    end
  endtask

  int lat;
  int nb;
  int nd;
  int wr0;
  int diffs;

  initial begin
    for (int i = 0; i < 256; i++) set_mem(8'(i), 32'h5A00_0000 | i);
    set_mem(8'h01, 32'h0000_1111);
    for (int i = 0; i < 4; i++) set_mem(8'h20 + 8'(i), 32'hA0 + i);
    for (int i = 0; i < 3; i++) set_mem(8'h30 + 8'(i), 32'hB000_0030 + i);
    set_mem(8'hFE, 32'hFEED_00FE);
    set_mem(8'h60, 32'hC0C0_0060);
    set_mem(8'h61, 32'hC0C0_0061);
    set_mem(8'h71, 32'h7171_7171);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_req", {63'd0, m_req}, 64'd0);
    chk("rst_addr", {56'd0, m_address}, 64'd0);
    chk("rst_dout", {32'd0, m_dout}, 64'd0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);

    // single word; start during DONE is ignored
    wr0 = n_wr;
    do_start(8'h01, 8'h10, 8'd1, 0);
    observe(16, 5, -10, 8'h00, lat, nb, nd);
    chk("t1_lat", 64'(lat), 64'd5);
    chk("t1_ndone", 64'(nd), 64'd1);
    chk("t1_mem", {32'd0, mem[8'h10]}, 64'h0000_1111);
    chk("t1_nwr", 64'(n_wr - wr0), 64'd1);

    // burst with a start pulse while busy
    wr0 = n_wr;
    do_start(8'h20, 8'h40, 8'd4, 0);
    observe(22, 5, -10, 8'h00, lat, nb, nd);
    chk("t2_busy_cycles", 64'(nb), 64'd14);
    chk("t2_ndone", 64'(nd), 64'd1);
    chk("t2_nwr", 64'(n_wr - wr0), 64'd4);
    chk("t2_mem43", {32'd0, mem[8'h43]}, 64'h0000_00A3);

    // zero length
    wr0 = n_wr;
    do_start(8'h05, 8'h06, 8'd0, 0);
    observe(6, -10, -10, 8'h00, lat, nb, nd);
    chk("t3_lat", 64'(lat), 64'd0);
    chk("t3_busy_cycles", 64'(nb), 64'd0);
    chk("t3_nwr", 64'(n_wr - wr0), 64'd0);

    // grant stall during RDW of word 2
    do_start(8'h30, 8'h50, 8'd3, 3);
    observe(20, -10, 6, 8'h31, lat, nb, nd);
    chk("t4_lat", 64'(lat), 64'd14);
    chk("t4_mem51", {32'd0, mem[8'h51]}, 64'hB000_0031);

    // address wrap with overlapping ranges
    do_start(8'hFE, 8'hFF, 8'd3, 0);
    observe(16, -10, -10, 8'h00, lat, nb, nd);
    chk("t5_lat", 64'(lat), 64'd11);
    chk("t5_memFF", {32'd0, mem[8'hFF]}, 64'hFEED_00FE);
    chk("t5_mem00", {32'd0, mem[8'h00]}, 64'hFEED_00FE);
    chk("t5_mem01", {32'd0, mem[8'h01]}, 64'hFEED_00FE);

    // reset while in WR of word 2
    do_start(8'h60, 8'h70, 8'd3, 0);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    armed = 1'b0;
    q.delete();
    reset_n = 1'b0;
    #1;
    chk("t6_req", {63'd0, m_req}, 64'd0);
    chk("t6_wr", {63'd0, m_wr}, 64'd0);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    chk("t6_done", {63'd0, done}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_mem70", {32'd0, mem[8'h70]}, 64'hC0C0_0060);
    chk("t6_mem71", {32'd0, mem[8'h71]}, 64'h7171_7171);
    do_start(8'h60, 8'h71, 8'd1, 0);
    observe(12, -10, -10, 8'h00, lat, nb, nd);
    chk("t6_fresh_lat", 64'(lat), 64'd5);
    chk("t6_mem71_new", {32'd0, mem[8'h71]}, 64'hC0C0_0060);

    // final memory image against the model
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== shadow[i]) diffs++;
    chk("mem_vs_model", 64'(diffs), 64'd0);
    chk("queue_drained", 64'(q.size()), 64'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
